// File: rtl/squeeze_window_buffer.sv
// squeeze_window_buffer
//   Captures one squeeze-layer output (CHANNELS channels x 3x3 pixels, one
//   channel per beat). It then replays zero-padded 3x3 windows to the 9-PE
//   expand array. The replay order is filter -> position -> channel, and PE
//   lane n receives window element n.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous abort back to FILL
//   wr_valid/wr_ready   channel beat handshake (accepting only in FILL)
//   wr_data             pixels p0..p8 of one channel, p0 in LSBs
//   win_valid/win_ready window beat handshake
//   win_data            PE lane inputs 0..8, lane 0 in LSBs
//   win_pos, win_ch     output position j (0..8) and channel k of the beat
//   win_filt            filter index i
//   win_last_ch         k == CHANNELS-1 (accumulate/bias point)
//   win_last            final beat of the whole pass
//   mode_1x1            only with WINBUF_1X1_EN defined. When 1, it is
//                       sampled on FILL->STREAM and selects the 1x1 feed:
//                       j=4 only, unpadded.
module squeeze_window_buffer #(
  parameter int DATA_W      = 8,
  parameter int CHANNELS    = 32,
  parameter int NUM_FILTERS = 128,
  parameter int PAD_VALUE   = 0,
  localparam int CW = $clog2(CHANNELS),
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9*DATA_W-1:0] wr_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [9*DATA_W-1:0] win_data,
  output logic [3:0]        win_pos,
  output logic [CW-1:0]     win_ch,
  output logic [FW-1:0]     win_filt,
  output logic              win_last_ch,
  output logic              win_last
`ifdef WINBUF_1X1_EN
  ,
  input  logic              mode_1x1
`endif
);

  typedef enum logic {FILL, STREAM} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [FW-1:0]       filt_q, filt_d;
  logic [3:0]          pos_q, pos_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic                valid_q, valid_d;
  logic [9*DATA_W-1:0] data_q, data_d;
  logic                last_ch_q, last_ch_d;
  logic                last_q, last_d;
  logic                mode_q, mode_d;
  logic                mode_in;
  logic                wr_fire;

  logic [9*DATA_W-1:0] mem [CHANNELS];

`ifdef WINBUF_1X1_EN
  assign mode_in = mode_1x1;
`else
  assign mode_in = 1'b0;
`endif

  assign wr_ready    = (state_q == FILL);
  assign win_valid   = valid_q;
  assign win_data    = data_q;
  assign win_pos     = pos_q;
  assign win_ch      = ch_q;
  assign win_filt    = filt_q;
  assign win_last_ch = last_ch_q;
  assign win_last    = last_q;

  assign wr_fire = rst_n && !flush && (state_q == FILL) && wr_valid;

  // Window for output position pos: lane r*3+c takes pixel
  // (prow+r-1, pcol+c-1). Any pixel off the 3x3 map becomes PAD_VALUE.
  function automatic logic [9*DATA_W-1:0] build_window(
    input logic [9*DATA_W-1:0] pix,
    input logic [3:0]          pos
  );
    logic [9*DATA_W-1:0] w;
    int prow, pcol, rr, cc;
    w    = '0;
    prow = int'(pos) / 3;
    pcol = int'(pos) % 3;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        rr = prow + int'(r) - 1;
        cc = pcol + int'(c) - 1;
        if (rr < 0 || rr > 2 || cc < 0 || cc > 2)
          w[(r*3+c)*DATA_W +: DATA_W] = DATA_W'(PAD_VALUE);
        else
          w[(r*3+c)*DATA_W +: DATA_W] = pix[(rr*3+cc)*DATA_W +: DATA_W];
      end
    end
    return w;
  endfunction

  // Pixel storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_cnt_q] <= wr_data;
  end

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    filt_d    = filt_q;
    pos_d     = pos_q;
    ch_d      = ch_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_ch_d = last_ch_q;
    last_d    = last_q;
    mode_d    = mode_q;

    if (flush) begin
      state_d   = FILL;
      wr_cnt_d  = '0;
      filt_d    = '0;
      pos_d     = '0;
      ch_d      = '0;
      valid_d   = 1'b0;
      data_d    = '0;
      last_ch_d = 1'b0;
      last_d    = 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (wr_valid) begin
            if (wr_cnt_q == CW'(CHANNELS-1)) begin
              // Channel 0 was stored on an earlier beat (CHANNELS >= 2).
              // The first window can therefore be registered on this edge.
              state_d   = STREAM;
              wr_cnt_d  = '0;
              filt_d    = '0;
              ch_d      = '0;
              mode_d    = mode_in;
              pos_d     = mode_in ? 4'd4 : 4'd0;
              valid_d   = 1'b1;
              data_d    = build_window(mem[0], pos_d);
              last_ch_d = 1'b0;
              last_d    = 1'b0;
            end else begin
              wr_cnt_d = wr_cnt_q + 1'b1;
            end
          end
        end
        STREAM: begin
          if (win_ready) begin
            if (last_q) begin
              state_d   = FILL;
              filt_d    = '0;
              pos_d     = '0;
              ch_d      = '0;
              valid_d   = 1'b0;
              data_d    = '0;
              last_ch_d = 1'b0;
              last_d    = 1'b0;
            end else begin
              if (ch_q == CW'(CHANNELS-1)) begin
                ch_d = '0;
                if (mode_q || pos_q == 4'd8) begin
                  pos_d  = mode_q ? 4'd4 : 4'd0;
                  filt_d = filt_q + 1'b1;
                end else begin
                  pos_d = pos_q + 4'd1;
                end
              end else begin
                ch_d = ch_q + 1'b1;
              end
              data_d    = build_window(mem[ch_d], pos_d);
              last_ch_d = (ch_d == CW'(CHANNELS-1));
              last_d    = (filt_d == FW'(NUM_FILTERS-1)) && (mode_q || pos_d == 4'd8) &&
                          (ch_d == CW'(CHANNELS-1));
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      wr_cnt_q  <= '0;
      filt_q    <= '0;
      pos_q     <= '0;
      ch_q      <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_ch_q <= 1'b0;
      last_q    <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      filt_q    <= filt_d;
      pos_q     <= pos_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_ch_q <= last_ch_d;
      last_q    <= last_d;
      mode_q    <= mode_d;
    end
  end

endmodule

// File: tb/tb_squeeze_window_buffer.sv
module tb_squeeze_window_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  flush = '0, wr_valid = '0, win_ready = '0;
  logic [71:0] wr_data [2];

  logic [1:0]  o_wr_ready, o_valid, o_last_ch, o_last;
  logic [71:0] o_data [2];
  logic [3:0]  o_pos [2];
  logic [7:0]  o_ch [2], o_filt [2];

  logic [4:0] ch0;
  logic [1:0] ch1;
  logic [0:0] f0, f1;

  squeeze_window_buffer #(.DATA_W(8), .CHANNELS(32), .NUM_FILTERS(2), .PAD_VALUE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]), .wr_valid(wr_valid[0]),
    .wr_ready(o_wr_ready[0]), .wr_data(wr_data[0]), .win_valid(o_valid[0]),
    .win_ready(win_ready[0]), .win_data(o_data[0]), .win_pos(o_pos[0]),
    .win_ch(ch0), .win_filt(f0), .win_last_ch(o_last_ch[0]), .win_last(o_last[0]));

  squeeze_window_buffer #(.DATA_W(8), .CHANNELS(4), .NUM_FILTERS(2), .PAD_VALUE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]), .wr_valid(wr_valid[1]),
    .wr_ready(o_wr_ready[1]), .wr_data(wr_data[1]), .win_valid(o_valid[1]),
    .win_ready(win_ready[1]), .win_data(o_data[1]), .win_pos(o_pos[1]),
    .win_ch(ch1), .win_filt(f1), .win_last_ch(o_last_ch[1]), .win_last(o_last[1]));

  assign o_ch[0]   = 8'(ch0);
  assign o_ch[1]   = 8'(ch1);
  assign o_filt[0] = 8'(f0);
  assign o_filt[1] = 8'(f1);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int d, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 32 : 4;
  endfunction

  function automatic int total(input int d);
    return 2 * 9 * nch(d);
  endfunction

  // Reference window: lane l=(r,c) sees pixel (j/3+r-1, j%3+c-1), zero off-map.
  function automatic logic [71:0] exp_win(input logic [71:0] pix, input int j);
    logic [71:0] w;
    int y, x;
    w = '0;
    for (int l = 0; l < 9; l++) begin
      y = j / 3 + l / 3 - 1;
      x = j % 3 + l % 3 - 1;
      if (y >= 0 && y <= 2 && x >= 0 && x <= 2) w[l*8 +: 8] = pix[(y*3+x)*8 +: 8];
    end
    return w;
  endfunction

  // Behavioural model: a pass is just a beat counter 0..total-1.
  // (i,j,k) are derived from the beat index.
  bit          m_fill [2] = '{1'b1, 1'b1};
  int          m_wr   [2] = '{0, 0};
  int          m_beat [2] = '{0, 0};
  logic [71:0] mp [2][32];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || flush[d]) begin
        m_fill[d] <= 1'b1;
        m_wr[d]   <= 0;
        m_beat[d] <= 0;
      end else if (m_fill[d]) begin
        if (wr_valid[d]) begin
          mp[d][m_wr[d]] <= wr_data[d];
          if (m_wr[d] == nch(d) - 1) begin
            m_fill[d] <= 1'b0;
            m_wr[d]   <= 0;
            m_beat[d] <= 0;
          end else begin
            m_wr[d] <= m_wr[d] + 1;
          end
        end
      end else if (win_ready[d]) begin
        if (m_beat[d] == total(d) - 1) begin
          m_fill[d] <= 1'b1;
          m_beat[d] <= 0;
        end else begin
          m_beat[d] <= m_beat[d] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int b, c, ek, ej, ei;
    for (int d = 0; d < 2; d++) begin
      chk("wr_ready", d, 72'(o_wr_ready[d]), 72'(m_fill[d]));
      chk("win_valid", d, 72'(o_valid[d]), 72'(!m_fill[d]));
      if (!m_fill[d]) begin
        b  = m_beat[d];
        c  = nch(d);
        ek = b % c;
        ej = (b / c) % 9;
        ei = b / (9 * c);
        chk("win_data", d, o_data[d], exp_win(mp[d][ek], ej));
        chk("win_pos", d, 72'(o_pos[d]), 72'(ej));
        chk("win_ch", d, 72'(o_ch[d]), 72'(ek));
        chk("win_filt", d, 72'(o_filt[d]), 72'(ei));
        chk("win_last_ch", d, 72'(o_last_ch[d]), 72'(ek == c - 1));
        chk("win_last", d, 72'(o_last[d]), 72'(b == total(d) - 1));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the last write edge.
  task automatic fill(input int d, input bit pattern);
    int n = 0;
    for (int cyc = 0; cyc < 1000 && n < nch(d); cyc++) begin
      if (pattern || $urandom_range(0, 3) != 0) begin
        wr_valid[d] = 1'b1;
        for (int p = 0; p < 9; p++)
          wr_data[d][p*8 +: 8] = pattern ? 8'(n * 9 + p) : 8'($urandom);
        n++;
      end else begin
        wr_valid[d] = 1'b0;
        wr_data[d]  = {$urandom, $urandom, $urandom};
      end
      @(negedge clk);
    end
    wr_valid[d] = 1'b0;
  endtask

  // target < 0 means run until the pass ends (model back in FILL).
  task automatic run_until(input int d, input int target, input bit rnd);
    bit ok = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (target < 0 ? m_fill[d] : (!m_fill[d] && m_beat[d] == target)) begin
        ok = 1;
        break;
      end
      win_ready[d] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL run_until dut%0d target=%0d not reached", d, target);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [71:0] e, held;
    int beats, nlc, last_at;
    wr_data[0] = '0;
    wr_data[1] = '0;

    // Reset with wr_valid high: nothing may be written.
    wr_valid = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", 0, 72'(o_wr_ready[0]), 72'd1);
    chk("rst_win_valid", 0, 72'(o_valid[0]), 72'd0);
    chk("rst_win_data", 0, o_data[0], 72'd0);
    chk("rst_win_data", 1, o_data[1], 72'd0);
    wr_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    // Pattern fill; the first window is valid right after the last write.
    win_ready[0] = 1'b1;
    fill(0, 1'b1);
    chk("first_valid", 0, 72'(o_valid[0]), 72'd1);
    e = '0;
    e[5*8 +: 8] = 8'd1;
    e[7*8 +: 8] = 8'd3;
    e[8*8 +: 8] = 8'd4;
    chk("first_beat_data", 0, o_data[0], e);
    chk("first_beat_pos", 0, 72'(o_pos[0]), 72'd0);

    // Backpressure at j=2, k=7.
    run_until(0, 2 * 32 + 7, 1'b0);
    win_ready[0] = 1'b0;
    held = o_data[0];
    repeat (5) @(negedge clk);
    chk("bp_hold_data", 0, o_data[0], held);
    chk("bp_hold_pos", 0, 72'(o_pos[0]), 72'd2);
    chk("bp_hold_ch", 0, 72'(o_ch[0]), 72'd7);
    win_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_resume_ch", 0, 72'(o_ch[0]), 72'd8);
    chk("bp_resume_pos", 0, 72'(o_pos[0]), 72'd2);

    // j=4, k=1: centre window is channel 1 unpadded, codes 9..17.
    run_until(0, 4 * 32 + 1, 1'b0);
    for (int n = 0; n < 9; n++) e[n*8 +: 8] = 8'(9 + n);
    chk("centre_data", 0, o_data[0], e);
    run_until(0, -1, 1'b1);
    chk("pass_end_wr_ready", 0, 72'(o_wr_ready[0]), 72'd1);

    // Flush at i=1, j=3, then refill and stream from the start.
    fill(0, 1'b0);
    run_until(0, 288 + 3 * 32 + $urandom_range(0, 31), 1'b1);
    flush[0] = 1'b1;
    win_ready[0] = 1'($urandom_range(0, 1));
    @(negedge clk);
    flush[0] = 1'b0;
    chk("flush_valid", 0, 72'(o_valid[0]), 72'd0);
    chk("flush_wr_ready", 0, 72'(o_wr_ready[0]), 72'd1);
    fill(0, 1'b0);
    chk("refill_filt", 0, 72'(o_filt[0]), 72'd0);
    chk("refill_pos", 0, 72'(o_pos[0]), 72'd0);
    chk("refill_ch", 0, 72'(o_ch[0]), 72'd0);
    run_until(0, -1, 1'b1);

    // Small configuration, always ready: count beats and flags.
    win_ready[1] = 1'b1;
    fill(1, 1'b0);
    beats = 0;
    nlc = 0;
    last_at = 0;
    for (int cyc = 0; cyc < 200 && o_valid[1]; cyc++) begin
      beats++;
      if (o_last_ch[1]) nlc++;
      if (o_last[1]) last_at = beats;
      @(negedge clk);
    end
    chk("seq_beats", 1, 72'(beats), 72'd72);
    chk("seq_last_ch_count", 1, 72'(nlc), 72'd18);
    chk("seq_last_at", 1, 72'(last_at), 72'd72);
    chk("seq_wr_ready", 1, 72'(o_wr_ready[1]), 72'd1);

    // Random passes on the small configuration.
    for (int p = 0; p < 3; p++) begin
      fill(1, 1'b0);
      run_until(1, -1, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
